// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared stall-mode constants, LFSR polynomial and latched-request type
package mem_bus_pkg;
  localparam int STALL_NONE = 0;
  localparam int STALL_FIXED = 1;
  localparam int STALL_RAND = 2;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int REQ_ADDR_MAX = 64;
  localparam int REQ_DATA_MAX = 256;
  // Sized for the widest supported bus; narrower buses zero-extend into it
  typedef struct packed {
    logic wen;
    logic [REQ_DATA_MAX/8-1:0] strb;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_bus_responder_lfsr16.sv
// lfsr16: free-running 16-bit right-shifting Galois LFSR with reset seed
module lfsr16
  import mem_bus_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0);
  assign lfsr_o = lfsr_q;
  always_ff @(posedge clock) lfsr_q <= reset ? SEED : lfsr_d;
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: stateful SRAM-bus slave with stall insertion, decode errors and hold-while-stalled checking
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int STALL_MODE = 0,
  parameter int FIXED_STALL = 2,
  parameter int MAX_STALL = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_cen,
  input  logic                  mem_wen,
  input  logic [DATA_W/8-1:0]   mem_strb,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_stall,
  output logic                  mem_error,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  proto_err,
  output logic [31:0]           stat_stalls
);
  localparam int B = $clog2(DATA_W / 8);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_STALL + 1);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, n, stat_q;
  req_t req_q, req_d, cur;
  logic proto_q, proto_d, accept, bad, err_q, unused_lfsr;
  logic [15:0] lfsr;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] store [DEPTH];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clock(clock), .reset(reset), .lfsr_o(lfsr));

  assign unused_lfsr = ^lfsr;
  assign cur = '{wen: mem_wen, strb: (REQ_DATA_MAX/8)'(mem_strb),
                 addr: REQ_ADDR_MAX'(mem_addr), wdata: REQ_DATA_MAX'(mem_wdata)};
  assign n = STALL_MODE == STALL_FIXED ? 32'(FIXED_STALL)
           : STALL_MODE == STALL_RAND ? 32'(lfsr[SW-1:0]) : 32'd0;
  // Misaligned, or any address bit above the word index set
  assign bad = (mem_addr & ADDR_W'(DATA_W / 8 - 1)) != '0 || (mem_addr >> (IW + B)) != '0;
  assign idx = IW'(mem_addr >> B);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    proto_d = proto_q;
    mem_stall = 1'b0;
    accept = 1'b0;
    if (reset) begin
      mem_stall = 1'b1;
    end else if (state_q == IDLE) begin
      if (mem_cen && n == 0) begin
        accept = 1'b1;
      end else if (mem_cen) begin
        mem_stall = 1'b1;
        req_d = cur;
        cnt_d = n - 32'd1;
        state_d = WAIT;
      end
    end else if (!mem_cen) begin
      proto_d = 1'b1;
      state_d = IDLE;
    end else begin
      proto_d = proto_q | (cur != req_q);
      mem_stall = cnt_q != 0;
      cnt_d = cnt_q != 0 ? cnt_q - 32'd1 : cnt_q;
      accept = cnt_q == 0;
      state_d = cnt_q == 0 ? IDLE : WAIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= '0;
      proto_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      stat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      proto_q <= proto_d;
      err_q <= accept & bad;
      rdata_q <= (accept && !bad && !mem_wen) ? store[idx] : '0;
      if (mem_cen && mem_stall && stat_q != '1) stat_q <= stat_q + 32'd1;
    end
  end

  always_ff @(posedge clock)
    if (accept && mem_wen && !bad)
      for (int i = 0; i < DATA_W / 8; i++)
        if (mem_strb[i]) store[idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];

  assign mem_error = err_q;
  assign mem_rdata = rdata_q;
  assign proto_err = proto_q;
  assign stat_stalls = stat_q;
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Parametrised slave model for the core's SRAM-style memory bus (cen/wen/strb/addr/wdata → rdata/stall/error).
- Replaces free-running random stall/error/rdata inputs in formal and simulation harnesses with a stateful backing store, deterministic or pseudo-random stall insertion, and range/alignment error generation.
- One instance per bus: instruction and data.
- Also checks the requester's hold-while-stalled obligation.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; power of two, ≥ 8.
- DEPTH, 1024, backing-store words; power of two.
- STALL_MODE, 0, stall policy: 0 = never, 1 = fixed, 2 = LFSR-random.
- FIXED_STALL, 2, stall cycles per request in mode 1.
- MAX_STALL, 3, maximum stall cycles in mode 2; power of two minus 1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clock  in  1  global clock.
- reset  in  1  synchronous, active-high reset.
- mem_cen  in  1  request valid.
- mem_wen  in  1  write request.
- mem_strb  in  DATA_W/8  byte write strobes.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  DATA_W  write data.
- mem_stall  out  1  request not accepted this cycle.
- mem_error  out  1  response error, response cycle only.
- mem_rdata  out  DATA_W  read data, response cycle only.
- proto_err  out  1  sticky requester-protocol violation.
- stat_stalls  out  32  saturating count of stalled cycles.

Behaviour:
- Acceptance
  - A request is accepted in the cycle where mem_cen=1 and mem_stall=0.
  - The response (mem_rdata, mem_error) is registered and valid exactly one cycle after acceptance.
- Stall count n, sampled when a request arrives in IDLE:
  - Mode 0: n = 0.
  - Mode 1: n = FIXED_STALL.
  - Mode 2: n = lfsr[log2(MAX_STALL+1)-1:0].
- FSM states: IDLE, WAIT.
  - IDLE, mem_cen=0: mem_stall=0; stay.
  - IDLE, mem_cen=1, n=0: mem_stall=0; accept.
  - IDLE, mem_cen=1, n>0: mem_stall=1; latch {wen, strb, addr, wdata}; cnt ← n-1; go to WAIT.
  - WAIT: mem_stall = (cnt≠0); cnt decrements each cycle.
  - WAIT, cnt=0: mem_stall=0; accept; go to IDLE.
  - Net effect: n consecutive stall cycles, then the accept cycle.
- Protocol checks in WAIT (set proto_err; cleared only by reset):
  - mem_cen=0: return to IDLE, no access.
  - Any of wen/strb/addr/wdata differs from the latched value: flag only; the access proceeds using the live values.
- Decode
  - Word index = mem_addr[log2(DEPTH)+B-1:B], where B = log2(DATA_W/8).
  - Error if mem_addr[B-1:0]≠0, or if any address bit above the index is non-zero.
- Response cycle
  - Error: mem_error=1, mem_rdata=0, no store update.
  - Read: mem_rdata = store word, mem_error=0.
  - Write: store updated per strobe byte at the accept edge; mem_rdata=0; strb=0 is a legal no-op.
  - Back-to-back: a read accepted the cycle after a write to the same word returns the new data.
- Outside response cycles: mem_rdata=0, mem_error=0.
- LFSR
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shifts right every cycle.
  - Advances every cycle regardless of traffic, so the stall pattern depends on absolute cycle.
- stat_stalls increments on every cycle with mem_cen&mem_stall; saturates at 2^32-1.
- Reset values:
  - State IDLE, cnt=0, lfsr=LFSR_SEED.
  - mem_rdata=0, mem_error=0, proto_err=0, stat_stalls=0.
  - While reset=1, mem_stall=1 and nothing is accepted.
- Reset mid-WAIT abandons the request: no write, no response.
- Store contents are not reset; they are undefined until written. The formal harness constrains them as free initial values.

Decomposition:
- Package mem_bus_pkg:
  - Stall-mode constants STALL_NONE / STALL_FIXED / STALL_RAND.
  - LFSR polynomial constant.
  - Typedef for the latched request struct.
- One sub-module, lfsr16: clock, reset, seed parameter, 16-bit state output. It is reused for random interrupt generation in the harness.

Test Plan:
- Mode 0: write 0xDEADBEEF to 0x10 with strb=4'hF, then read 0x10 back-to-back → mem_stall never high; read response 0xDEADBEEF one cycle after accept; mem_error=0.
- Mode 1, FIXED_STALL=2: read 0x20 held stable → mem_stall high 2 cycles, accept on cycle 3, response cycle 4; stat_stalls=2.
- Partial write: store holds 0x11223344 at 0x8; write 0xAABBCCDD with strb=4'b0101 → read returns 0x11BB33DD.
- Errors, DEPTH=1024: read 0x1000 → mem_error=1, mem_rdata=0; write to 0x2 → mem_error=1, store unchanged.
- Protocol: mode 1, change mem_addr 0x20→0x24 during stall → proto_err=1 and stays set; drop mem_cen mid-WAIT → FSM back in IDLE, no write.
- Reset mid-WAIT with a write pending → no store update; after reset, mem_stall=0 in mode 0 and lfsr equals 16'hACE1.
